tty_iot: RTL

PDP-8 console teletype controller (KL8E-compatible) sitting between the CPU's IOT decode and the UART. Executes keyboard (device 03) and printer (device 04) IOT microinstructions, owns the keyboard/printer flags and interrupt enable, and drives the UART's strobe/ready handshake on both directions. The CPU sees only AC transfer, skip and interrupt request.

---
 rtl/tty_iot_pkg.sv | 29 ++
 rtl/tty_iot_if.sv | 33 +++
 rtl/tty_rxfifo.sv | 45 ++++
 rtl/tty_iot.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/tty_iot_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tty_iot_pkg : shared constants and types for the console TTY block  |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
package tty_iot_pkg;

   localparam logic [5:0] KBD_DEV_CODE = 6'o03;
   localparam logic [5:0] PRT_DEV_CODE = 6'o04;

   // Op bits combine; these name the bit roles plus the codes that break the pattern.
   localparam int OP_SKIP = 0;
   localparam int OP_CLR  = 1;
   localparam int OP_XFER = 2;

   localparam logic [2:0] KOP_KCF = 3'd0;
   localparam logic [2:0] KOP_KIE = 3'd5;
   localparam logic [2:0] POP_TFL = 3'd0;
   localparam logic [2:0] POP_TSK = 3'd5;

   typedef enum logic [1:0] {
      TX_IDLE    = 2'd0,
      TX_STB     = 2'd1,
      TX_WAIT_LO = 2'd2,
      TX_WAIT_HI = 2'd3
   } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/tty_iot_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tty_iot_if : CPU IOT and UART handshake signals of the TTY block    |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
interface tty_iot_if;
   logic        iotStb;
   logic [5:0]  device;
   logic [2:0]  op;
   logic [11:0] acIn;
   logic [11:0] acOut;
   logic        acLoad;
   logic        skip;
   logic        iotDone;
   logic        irq;
   logic [7:0]  txData;
   logic        txStb;
   logic        txRdy;
   logic [7:0]  rxData;
   logic        rxRdy;
   logic        rxAck;

   modport slave (
      input  iotStb, device, op, acIn, txRdy, rxData, rxRdy,
      output acOut, acLoad, skip, iotDone, irq, txData, txStb, rxAck
   );

   modport master (
      output iotStb, device, op, acIn, txRdy, rxData, rxRdy,
      input  acOut, acLoad, skip, iotDone, irq, txData, txStb, rxAck
   );
endinterface
`default_nettype wire

// File: rtl/tty_rxfifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tty_rxfifo : synchronous receive FIFO, head always visible          |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module tty_rxfifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             i_push,
   input  wire logic [WIDTH-1:0] i_data,
   input  wire logic             i_pop,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [WIDTH-1:0]      o_head
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      r_wr, r_rd;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_doPush, w_doPop;

   assign o_empty  = (r_wr == r_rd);
   assign o_full   = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign o_head   = r_mem[r_rd[AW-1:0]];
   assign w_doPush = i_push && !o_full;
   assign w_doPop  = i_pop && !o_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr <= '0;
         r_rd <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_doPush) begin
            r_mem[r_wr[AW-1:0]] <= i_data;
            r_wr                <= r_wr + 1'b1;
         end
         if (w_doPop) r_rd <= r_rd + 1'b1;
      end
   end
endmodule
`default_nettype wire

// File: rtl/tty_iot.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tty_iot : KL8E-style console teletype controller (devices 03/04)    |
// | Define TTY_RXFIFO_EN for a receive FIFO ahead of the keyboard buffer|
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module tty_iot
   import tty_iot_pkg::*;
#(
   parameter logic [5:0] KBD_DEV      = KBD_DEV_CODE,
   parameter logic [5:0] PRT_DEV      = PRT_DEV_CODE,
   parameter int         RXFIFO_DEPTH = 4
) (
   input  wire logic clk,
   input  wire logic rst_n,
   tty_iot_if.slave  bus
);
   logic        w_kbdSel, w_prtSel, w_kbdClr, w_kie, w_prtSet, w_prtClr, w_print;
   logic        w_skip, w_kbdFlag, w_push, w_txGo, w_txDone;
   logic [7:0]  w_kbdBuf;
   logic [11:0] w_acNext;
   tx_state_t   r_txState, w_txNext;
   logic        r_iotDone, r_acLoad, r_skip, r_rxAck, r_prtFlag, r_ie, r_pend;
   logic [11:0] r_acOut;
   logic [7:0]  r_hold;

   generate
      if (RXFIFO_DEPTH < 2 || (RXFIFO_DEPTH & (RXFIFO_DEPTH - 1)) != 0) begin : g_bad_depth
         $error("RXFIFO_DEPTH must be a power of two, at least 2");
      end
   endgenerate

   assign w_kbdSel = bus.iotStb && (bus.device == KBD_DEV);
   assign w_prtSel = bus.iotStb && (bus.device == PRT_DEV);
   assign w_kbdClr = w_kbdSel && ((bus.op == KOP_KCF) || bus.op[OP_CLR]);
   assign w_kie    = w_kbdSel && (bus.op == KOP_KIE);
   assign w_prtSet = w_prtSel && (bus.op == POP_TFL);
   assign w_prtClr = w_prtSel && bus.op[OP_CLR];
   assign w_print  = w_prtSel && bus.op[OP_XFER] && !bus.op[OP_SKIP];

   always_comb begin
      w_skip = 1'b0;
      if (w_kbdSel)
         w_skip = bus.op[OP_SKIP] && (bus.op != KOP_KIE) && w_kbdFlag;
      else if (w_prtSel)
         w_skip = (bus.op == POP_TSK) ? (r_prtFlag || w_kbdFlag)
                                      : (bus.op[OP_SKIP] && r_prtFlag);
   end

   assign w_acNext = (bus.op[OP_CLR] ? 12'd0 : bus.acIn)
                   | ((w_kbdSel && bus.op[OP_XFER]) ? {4'd0, w_kbdBuf} : 12'd0);

`ifdef TTY_RXFIFO_EN
   logic w_full, w_empty;

   // r_rxAck gates the push so a slow UART release cannot double-load one byte.
   assign w_push    = bus.rxRdy && !w_full && !r_rxAck;
   assign w_kbdFlag = !w_empty;

   tty_rxfifo #(.DEPTH(RXFIFO_DEPTH), .WIDTH(8)) u_rxfifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  (bus.rxData),
      .i_pop   (w_kbdClr),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_kbdBuf)
   );
`else
   logic       r_kbdFlag;
   logic [7:0] r_kbdBuf;

   assign w_push    = bus.rxRdy && !r_kbdFlag && !r_rxAck;
   assign w_kbdFlag = r_kbdFlag;
   assign w_kbdBuf  = r_kbdBuf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_kbdFlag <= 1'b0;
         r_kbdBuf  <= 8'd0;
      end else begin
         r_kbdFlag <= (r_kbdFlag && !w_kbdClr) || w_push;
         if (w_push) r_kbdBuf <= bus.rxData;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_iotDone <= 1'b0;
         r_acOut   <= 12'd0;
         r_acLoad  <= 1'b0;
         r_skip    <= 1'b0;
         r_rxAck   <= 1'b0;
         r_prtFlag <= 1'b0;
         r_ie      <= 1'b1;
         r_hold    <= 8'd0;
         r_pend    <= 1'b0;
      end else begin
         r_iotDone <= w_kbdSel || w_prtSel;
         r_acOut   <= (w_kbdSel || w_prtSel) ? w_acNext : 12'd0;
         r_acLoad  <= w_kbdSel && (bus.op[OP_CLR] || bus.op[OP_XFER]);
         r_skip    <= w_skip;
         r_rxAck   <= w_push;
         r_prtFlag <= (r_prtFlag && !w_prtClr) || w_prtSet || w_txDone;
         if (w_kie)   r_ie   <= bus.acIn[0];
         if (w_print) r_hold <= bus.acIn[7:0];
         if (w_txGo)
            r_pend <= 1'b0;
         else if (w_print)
            r_pend <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_txState <= TX_IDLE;
      else        r_txState <= w_txNext;
   end

   // A print arriving in IDLE is launched directly so txStb follows the IOT by one cycle.
   always_comb begin
      w_txNext = r_txState;
      w_txGo   = 1'b0;
      w_txDone = 1'b0;
      case (r_txState)
         TX_IDLE: begin
            if ((r_pend || w_print) && bus.txRdy) begin
               w_txNext = TX_STB;
               w_txGo   = 1'b1;
            end
         end
         TX_STB:     w_txNext = TX_WAIT_LO;
         TX_WAIT_LO: if (!bus.txRdy) w_txNext = TX_WAIT_HI;
         TX_WAIT_HI: begin
            if (bus.txRdy) begin
               w_txNext = TX_IDLE;
               w_txDone = 1'b1;
            end
         end
         default:    w_txNext = TX_IDLE;
      endcase
   end

   assign bus.acOut   = r_acOut;
   assign bus.acLoad  = r_acLoad;
   assign bus.skip    = r_skip;
   assign bus.iotDone = r_iotDone;
   assign bus.irq     = r_ie && (w_kbdFlag || r_prtFlag);
   assign bus.txData  = r_hold;
   assign bus.txStb   = (r_txState == TX_STB);
   assign bus.rxAck   = r_rxAck;
endmodule
`default_nettype wire
